reg_file_2r1w_init: RTL and testbench
=====================================

Name: reg_file_2r1w_init

Overview:
- Parametrised successor register file: one write port, two independent asynchronous read ports.
- Adds an automatic post-reset clear sequencer with a `ready` flag, a runtime `clear` request, and optional write-to-read bypass.
- Used as the general-purpose register store for datapath blocks that need two operands per cycle and a known array state after reset.

Parameters:
- addr_width, 7, address bits; depth = 2**addr_width entries.
- data_width, 8, bits per entry.
- init_value, 0, data_width-bit value written to every entry by the clear sequencer.
- bypass, 1, 1 = a read of the address being written in the same cycle returns data_w; 0 = returns the old array contents.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  request a full re-initialisation; sampled only in RUN.
- we  input  1  write enable; honoured only when ready=1.
- address_w  input  addr_width  write address.
- data_w  input  data_width  write data.
- address_r0  input  addr_width  read port 0 address.
- address_r1  input  addr_width  read port 1 address.
- data_r0  output  data_width  read port 0 data (combinational).
- data_r1  output  data_width  read port 1 data (combinational).
- ready  output  1  1 = array initialised, accepting writes.
- parity_err  output  1  sticky parity error flag (see Optional Feature).

Behaviour:
- Clock and reset: single clock, clk. `reset` is asynchronous and active-high.
- Reset values: state=INIT, init_addr=0, ready=0, parity_err=0.
- Array: the array itself has no reset; it is cleared only by the sequencer.
- FSM states: INIT, RUN.
- INIT:
  - Each clk edge writes memory[init_addr] <= init_value and increments init_addr.
  - When init_addr == 2**addr_width-1, that entry is written and state moves to RUN on the same edge.
  - ready rises on the following cycle.
  - Duration: exactly 2**addr_width cycles from the first clk edge after reset deassertion until ready=1.
- INIT conditions:
  - we is ignored; no user write reaches the array.
  - clear is ignored.
  - data_r0 and data_r1 are forced to init_value.
- RUN:
  - ready=1.
  - If we=1, memory[address_w] <= data_w on the clk edge.
  - Reads are combinational: data_rN = memory[address_rN].
- Bypass (bypass=1, RUN, we=1, address_rN == address_w): data_rN = data_w in the same cycle. Both ports bypass independently.
- clear in RUN:
  - On the sampling edge, state -> INIT, init_addr <= 0, ready <= 0.
  - If we=1 in that same cycle, clear wins and the write is dropped.
- Reset mid-INIT or mid-RUN: immediately returns to INIT with init_addr=0; the sweep restarts from entry 0.
- Address wrap: init_addr is addr_width bits wide; the terminal-count compare precedes the increment, so it never wraps into a second pass.
- Both read ports may address the same entry; there is no arbitration.

Optional Feature:
- Macro: REG_FILE_PARITY_EN.
- Defined:
  - Each entry stores data_width+1 bits: data plus an even parity bit computed on write. The sequencer stores parity of init_value.
  - In RUN, a parity mismatch on either read port sets parity_err on the next clk edge.
  - parity_err is sticky; it clears only on reset or on entry to INIT via clear.
  - A bypassed read is not checked.
- Not defined: no parity storage; parity_err is tied to 0.

Test Plan (addr_width=3, data_width=8, init_value=8'hA5, bypass=1):
- Reset pulse, then release -> ready=0 for exactly 8 cycles, ready=1 in cycle 9; read all 8 addresses -> 8'hA5; writes with we=1 during INIT leave the array at 8'hA5.
- RUN: write 8'h3C @ addr 2, write 8'hF0 @ addr 5; read r0=2, r1=5 -> data_r0=8'h3C, data_r1=8'hF0; same-cycle read r0=r1=5 -> both 8'hF0.
- Bypass: we=1, address_w=4, data_w=8'h11, address_r0=4 in the same cycle -> data_r0=8'h11 before the edge. Repeat with bypass=0 -> data_r0=8'hA5.
- clear=1 with we=1 to addr 2 (8'h77) in the same cycle -> write dropped, ready=0 for 8 cycles, then addr 2 reads 8'hA5.
- Assert reset at INIT cycle 4 -> ready stays 0; the sweep restarts and ready rises 8 cycles after release.
- REG_FILE_PARITY_EN defined: force-flip bit 0 of entry 3, read r1=3 -> parity_err=1 next cycle and stays 1; clear -> parity_err=0. Macro undefined -> parity_err is always 0.

Source files
------------

// File: rtl/reg_file_2r1w_init.sv
// reg_file_2r1w_init: one write port, two combinational read ports, with a
// post-reset clear sequencer that sweeps init_value into every entry before
// raising ready. A runtime clear request restarts the same sweep.
// Optional feature macro: REG_FILE_PARITY_EN (adds an even-parity bit per
// entry and a sticky parity_err flag; without it parity_err is tied low).
//
// state | meaning
// INIT  | sweeping init_value into entry init_addr, user writes ignored
// RUN   | array valid, ready=1, user writes and clear requests accepted
module reg_file_2r1w_init #(
  parameter int                    addr_width = 7,
  parameter int                    data_width = 8,
  parameter logic [data_width-1:0] init_value = '0,
  parameter bit                    bypass     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  we,
  input  logic [addr_width-1:0] address_w,
  input  logic [data_width-1:0] data_w,
  input  logic [addr_width-1:0] address_r0,
  input  logic [addr_width-1:0] address_r1,
  output logic [data_width-1:0] data_r0,
  output logic [data_width-1:0] data_r1,
  output logic                  ready,
  output logic                  parity_err
);

  localparam int depth = 2 ** addr_width;
  localparam logic [addr_width-1:0] last_addr = {addr_width{1'b1}};

`ifdef REG_FILE_PARITY_EN
  localparam int mem_width = data_width + 1;
`else
  localparam int mem_width = data_width;
`endif

  typedef enum logic {INIT, RUN} state_t;

  state_t                state;
  logic [addr_width-1:0] init_addr;
  logic [mem_width-1:0]  mem [depth];
  logic [mem_width-1:0]  rd0_word;
  logic [mem_width-1:0]  rd1_word;
  logic [mem_width-1:0]  init_word;
  logic [mem_width-1:0]  wr_word;
  logic                  wr_en;
  logic                  byp0;
  logic                  byp1;

`ifdef REG_FILE_PARITY_EN
  assign init_word = {^init_value, init_value};
  assign wr_word   = {^data_w, data_w};
`else
  assign init_word = init_value;
  assign wr_word   = data_w;
`endif

  // A clear in the same cycle drops the write, so it must not bypass either.
  assign wr_en = (state == RUN) && we && !clear;
  assign byp0  = bypass && wr_en && (address_r0 == address_w);
  assign byp1  = bypass && wr_en && (address_r1 == address_w);

  assign rd0_word = mem[address_r0];
  assign rd1_word = mem[address_r1];

  // Read ports: forced to init_value while sweeping, else bypass or array.
  always_comb begin
    data_r0 = rd0_word[data_width-1:0];
    data_r1 = rd1_word[data_width-1:0];
    if (state == INIT) begin
      data_r0 = init_value;
      data_r1 = init_value;
    end else begin
      if (byp0) data_r0 = data_w;
      if (byp1) data_r1 = data_w;
    end
  end

  // Sequencer: terminal-count compare before increment, so a single pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      init_addr <= '0;
      ready     <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (init_addr == last_addr) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            init_addr <= init_addr + 1'b1;
          end
        end
        RUN: begin
          if (clear) begin
            state     <= INIT;
            init_addr <= '0;
            ready     <= 1'b0;
          end
        end
        default: begin
          state     <= INIT;
          init_addr <= '0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

  // Array write: the sweep owns the array in INIT, the user port in RUN.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[init_addr] <= init_word;
    end else if (wr_en) begin
      mem[address_w] <= wr_word;
    end
  end

`ifdef REG_FILE_PARITY_EN
  logic perr_q;

  // Sticky parity flag; bypassed reads never see the array so are not checked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else if (state == RUN) begin
      if (clear) begin
        perr_q <= 1'b0;
      end else if ((!byp0 && (^rd0_word)) || (!byp1 && (^rd1_word))) begin
        perr_q <= 1'b1;
      end
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_2r1w_init.sv
// Bench for reg_file_2r1w_init: two instances (bypass on / off) share stimulus
// and are compared against an array-level model of the register file.
module tb_reg_file_2r1w_init;

  localparam int         AW = 3;
  localparam int         DW = 8;
  localparam int         DEPTH = 8;
  localparam logic [7:0] IV = 8'hA5;

  logic          clk = 1'b0;
  logic          reset, clear, we;
  logic [AW-1:0] aw, ar0, ar1;
  logic [DW-1:0] dw;
  logic [DW-1:0] r0_b, r1_b, r0_n, r1_n;
  logic          rdy_b, rdy_n, perr_b, perr_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model [DEPTH];
  bit         m_ready;
  int         m_cnt;

  always #5 clk = ~clk;

  reg_file_2r1w_init #(.addr_width(AW), .data_width(DW), .init_value(IV), .bypass(1'b1)) dut (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .address_w(aw), .data_w(dw),
    .address_r0(ar0), .address_r1(ar1), .data_r0(r0_b), .data_r1(r1_b),
    .ready(rdy_b), .parity_err(perr_b));

  reg_file_2r1w_init #(.addr_width(AW), .data_width(DW), .init_value(IV), .bypass(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .address_w(aw), .data_w(dw),
    .address_r0(ar0), .address_r1(ar1), .data_r0(r0_n), .data_r1(r1_n),
    .ready(rdy_n), .parity_err(perr_n));

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (!m_ready) return IV;
    if (byp && we && !clear && a == aw) return dw;
    return model[a];
  endfunction

  task automatic enter_init();
    m_ready = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = IV;
  endtask

  task automatic check_all(input string tag);
    check1({tag, "_ready"},  rdy_b, m_ready);
    check1({tag, "_readyn"}, rdy_n, m_ready);
    check8({tag, "_r0"},     r0_b, exp_rd(ar0, 1'b1));
    check8({tag, "_r1"},     r1_b, exp_rd(ar1, 1'b1));
    check8({tag, "_r0n"},    r0_n, exp_rd(ar0, 1'b0));
    check8({tag, "_r1n"},    r1_n, exp_rd(ar1, 1'b0));
    check1({tag, "_perr"},   perr_b, 1'b0);
    check1({tag, "_perrn"},  perr_n, 1'b0);
  endtask

  // Update the model from the inputs present before the edge, then advance.
  task automatic tick();
    if (!reset) begin
      if (m_ready) begin
        if (clear) enter_init();
        else if (we) model[aw] = dw;
      end else begin
        m_cnt++;
        if (m_cnt == DEPTH) m_ready = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; we = 1'b0;
    aw = '0; ar0 = '0; ar1 = '0; dw = '0;
    enter_init();
    repeat (2) @(posedge clk);
    #1;
    check1("rst_ready", rdy_b, 1'b0);
    check1("rst_perr", perr_b, 1'b0);
    reset = 1'b0;

    // Power-up sweep with writes and clears thrown at it; both must be ignored.
    for (int k = 1; k <= DEPTH; k++) begin
      we    = 1'b1;
      clear = (k < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
      aw    = 3'($urandom_range(0, 7));
      dw    = 8'($urandom);
      ar0   = aw;
      ar1   = 3'($urandom_range(0, 7));
      #1;
      check_all("init");
      check1("init_ready0", rdy_b, 1'b0);
      tick();
    end
    we = 1'b0; clear = 1'b0;
    #1;
    check1("init_ready_c9", rdy_b, 1'b1);
    for (int a = 0; a < DEPTH; a++) begin
      ar0 = 3'(a);
      ar1 = 3'(DEPTH - 1 - a);
      #1;
      check8("post_init_r0", r0_b, IV);
      check_all("post_init");
    end

    // Directed writes and reads.
    we = 1'b1; aw = 3'd2; dw = 8'h3C; tick();
    aw = 3'd5; dw = 8'hF0; tick();
    we = 1'b0; ar0 = 3'd2; ar1 = 3'd5;
    #1;
    check8("wr_r0_a2", r0_b, 8'h3C);
    check8("wr_r1_a5", r1_b, 8'hF0);
    ar0 = 3'd5;
    #1;
    check8("same_r0_a5", r0_b, 8'hF0);
    check8("same_r1_a5", r1_b, 8'hF0);

    // Same-cycle bypass on port 0, compared across the two instances.
    we = 1'b1; aw = 3'd4; dw = 8'h11; ar0 = 3'd4; ar1 = 3'd4;
    #1;
    check8("byp_on_r0", r0_b, 8'h11);
    check8("byp_on_r1", r1_b, 8'h11);
    check8("byp_off_r0", r0_n, IV);
    check_all("byp");
    tick();
    we = 1'b0;
    #1;
    check8("byp_stored", r0_n, 8'h11);

    // Random traffic in RUN.
    repeat (300) begin
      we  = 1'($urandom_range(0, 1));
      aw  = 3'($urandom_range(0, 7));
      dw  = 8'($urandom);
      ar0 = ($urandom_range(0, 3) == 0) ? aw : 3'($urandom_range(0, 7));
      ar1 = ($urandom_range(0, 3) == 0) ? aw : 3'($urandom_range(0, 7));
      #1;
      check_all("rand");
      tick();
    end

    // clear beats a same-cycle write.
    we = 1'b1; aw = 3'd2; dw = 8'h77; clear = 1'b1; ar0 = 3'd2; ar1 = 3'd0;
    #1;
    check_all("clr_req");
    tick();
    we = 1'b0; clear = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      #1;
      check1("clr_ready0", rdy_b, 1'b0);
      tick();
    end
    check1("clr_ready1", rdy_b, 1'b1);
    check8("clr_a2", r0_b, IV);
    check_all("clr_done");

    // Reset at INIT cycle 4 restarts the sweep.
    clear = 1'b1; tick();
    clear = 1'b0;
    repeat (4) begin
      check_all("pre_rst");
      tick();
    end
    reset = 1'b1;
    enter_init();
    #1;
    check1("midrst_ready", rdy_b, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      #1;
      check1("midrst_ready0", rdy_b, 1'b0);
      tick();
    end
    check1("midrst_ready1", rdy_b, 1'b1);
    for (int a = 0; a < DEPTH; a++) begin
      ar0 = 3'(a);
      #1;
      check8("midrst_rd", r0_b, IV);
    end

`ifdef REG_FILE_PARITY_EN
    we = 1'b0; ar0 = 3'd0; ar1 = 3'd3;
    dut.mem[3][0] = ~dut.mem[3][0];
    #1;
    check1("par_before", perr_b, 1'b0);
    tick();
    check1("par_set", perr_b, 1'b1);
    check1("par_other", perr_n, 1'b0);
    ar1 = 3'd0;
    tick();
    check1("par_sticky", perr_b, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check1("par_clr", perr_b, 1'b0);
    repeat (DEPTH) tick();
    check_all("par_done");
`else
    ar1 = 3'd3;
    tick();
    check1("par_off", perr_b, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
